// File: rtl/sdcard_cmd_arbiter.sv
// sdcard_cmd_arbiter
//   Round-robin arbiter that collects SD-card commands from NUM_CH FPGA
//   requesters and issues them one at a time to the HPS SD-card service.
//   Each command completes on the HPS toggle-handshake response or times out.
//
// Ports
//   sd_clk, reset_n          clock, synchronous active-low reset
//   hOp, hData, hReqId       HPS response: opcode, payload, toggle strobe [1:0]
//   sys_cmd, sys_arg         per-channel command code / argument
//   sys_req                  per-channel request toggle (any edge = request)
//   sys_done, sys_err        per-channel 1-cycle completion / error pulses
//   sys_rdata                hData of the last successful completion
//   sys_busy                 command in flight
//   fCmd, fArg1, fReqId      command, argument and issue counter to the HPS
//   fDebug_info              debug word, 0 unless SDCARD_ARB_DEBUG_EN is defined
//   sdLed                    card-ready indicator
//
// Build option
//   SDCARD_ARB_DEBUG_EN      registers {state, cur, pending, fReqId, hOp}
//                            onto fDebug_info every cycle
module sdcard_cmd_arbiter #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ARG_WIDTH = 26,
    parameter int unsigned TIMEOUT   = 50000000
) (
    input  logic                          sd_clk,
    input  logic                          reset_n,
    input  logic [15:0]                   hOp,
    input  logic [31:0]                   hData,
    input  logic [15:0]                   hReqId,
    input  logic [NUM_CH*8-1:0]           sys_cmd,
    input  logic [NUM_CH*ARG_WIDTH-1:0]   sys_arg,
    input  logic [NUM_CH-1:0]             sys_req,
    output logic [NUM_CH-1:0]             sys_done,
    output logic [NUM_CH-1:0]             sys_err,
    output logic [31:0]                   sys_rdata,
    output logic                          sys_busy,
    output logic [7:0]                    fCmd,
    output logic [31:0]                   fArg1,
    output logic [15:0]                   fReqId,
    output logic [31:0]                   fDebug_info,
    output logic                          sdLed
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1
    } state_e;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   req_last_q, req_last_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   ovr_q, ovr_d;
    logic [NUM_CH-1:0]   done_q, done_d;
    logic [NUM_CH-1:0]   err_q, err_d;
    logic [1:0]          hreq_last_q, hreq_last_d;
    logic [2:0]          cur_q, cur_d;
    logic [2:0]          rr_q, rr_d;
    logic [7:0]          fcmd_q, fcmd_d;
    logic [31:0]         farg_q, farg_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [31:0]         tcnt_q, tcnt_d;
    logic [15:0]         freqid_q, freqid_d;
    logic                busy_q, busy_d;
    logic                led_q, led_d;

    logic                grant_vld;
    logic [2:0]          grant_idx;
    logic [NUM_CH-1:0]   grant_oh;
    logic [NUM_CH-1:0]   cur_oh;
    logic [7:0]          grant_cmd;
    logic [31:0]         grant_arg;
    logic [2:0]          rr_nx;

    logic [NUM_CH-1:0]   req_tog;
    logic                resp;
    logic [NUM_CH-1:0]   ovr_all;

    logic                unused_hi;
    assign unused_hi = ^{hOp[15:4], hReqId[15:2]};

    // First pending channel at or after the round-robin pointer.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_oh  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(rr_q) + i) % NUM_CH;
            for (int unsigned j = 0; j < NUM_CH; j++) begin
                if (!grant_vld && (j == idx) && pending_q[j]) begin
                    grant_vld   = 1'b1;
                    grant_idx   = 3'(j);
                    grant_oh[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grant_cmd = '0;
        grant_arg = '0;
        cur_oh    = '0;
        for (int unsigned j = 0; j < NUM_CH; j++) begin
            if (grant_oh[j]) begin
                grant_cmd                 = sys_cmd[j*8 +: 8];
                grant_arg[ARG_WIDTH-1:0]  = sys_arg[j*ARG_WIDTH +: ARG_WIDTH];
            end
            if (32'(cur_q) == j) begin
                cur_oh[j] = 1'b1;
            end
        end
        rr_nx = 3'((32'(grant_idx) + 1) % NUM_CH);
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        cur_d       = cur_q;
        rr_d        = rr_q;
        fcmd_d      = fcmd_q;
        farg_d      = farg_q;
        rdata_d     = rdata_q;
        tcnt_d      = tcnt_q;
        freqid_d    = freqid_q;
        busy_d      = busy_q;
        led_d       = led_q;
        done_d      = '0;
        err_d       = '0;
        req_last_d  = sys_req;
        hreq_last_d = hReqId[1:0];

        req_tog = sys_req ^ req_last_q;
        resp    = (hReqId[1:0] != hreq_last_q);

        unique case (state_q)
            S_IDLE: begin
                // Responses in IDLE are stale except for the card-ready notice.
                if (resp && (hOp[3:0] == 4'd1)) begin
                    led_d = 1'b1;
                end
                if (grant_vld) begin
                    fcmd_d    = grant_cmd;
                    farg_d    = grant_arg;
                    freqid_d  = freqid_q + 16'd1;
                    pending_d = pending_q & ~grant_oh;
                    cur_d     = grant_idx;
                    rr_d      = rr_nx;
                    tcnt_d    = '0;
                    busy_d    = 1'b1;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp && (hOp[3:0] == 4'd1)) begin
                    led_d = 1'b1;
                end
                // A completing response takes priority over a coincident timeout.
                if (resp && (hOp[3:0] != 4'd1)) begin
                    if (hOp[3:0] == 4'd15) begin
                        err_d = cur_oh;
                    end else begin
                        rdata_d = hData;
                        done_d  = cur_oh;
                    end
                    fcmd_d  = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tcnt_q == TO_LAST) begin
                    err_d   = cur_oh;
                    fcmd_d  = '0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Requests on a channel that is already pending are dropped as overruns.
        pending_d = pending_d | (req_tog & ~pending_q);

        // An overrun that collides with a done pulse on the same channel is
        // held one cycle so sys_done and sys_err never coincide.
        ovr_all = ovr_q | (req_tog & pending_q);
        err_d   = err_d | (ovr_all & ~done_d);
        ovr_d   = ovr_all & done_d;
    end

    always_ff @(posedge sd_clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            req_last_q  <= sys_req;
            hreq_last_q <= hReqId[1:0];
            pending_q   <= '0;
            ovr_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            cur_q       <= '0;
            rr_q        <= '0;
            fcmd_q      <= '0;
            farg_q      <= '0;
            rdata_q     <= '0;
            tcnt_q      <= '0;
            freqid_q    <= '0;
            busy_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_last_q  <= req_last_d;
            hreq_last_q <= hreq_last_d;
            pending_q   <= pending_d;
            ovr_q       <= ovr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cur_q       <= cur_d;
            rr_q        <= rr_d;
            fcmd_q      <= fcmd_d;
            farg_q      <= farg_d;
            rdata_q     <= rdata_d;
            tcnt_q      <= tcnt_d;
            freqid_q    <= freqid_d;
            busy_q      <= busy_d;
            led_q       <= led_d;
        end
    end

    assign sys_done  = done_q;
    assign sys_err   = err_q;
    assign sys_rdata = rdata_q;
    assign sys_busy  = busy_q;
    assign fCmd      = fcmd_q;
    assign fArg1     = farg_q;
    assign fReqId    = freqid_q;
    assign sdLed     = led_q;

`ifdef SDCARD_ARB_DEBUG_EN
    logic [31:0] dbg_q, dbg_d;
    logic [7:0]  pend8;

    always_comb begin
        pend8             = '0;
        pend8[NUM_CH-1:0] = pending_q;
        dbg_d             = {state_q, cur_q, 3'b000, pend8, freqid_q[7:0], hOp[7:0]};
    end

    always_ff @(posedge sd_clk) begin
        if (!reset_n) begin
            dbg_q <= '0;
        end else begin
            dbg_q <= dbg_d;
        end
    end

    assign fDebug_info = dbg_q;
`else
    assign fDebug_info = '0;
`endif

endmodule

// File: tb/tb_sdcard_cmd_arbiter.sv
// Directed bench for sdcard_cmd_arbiter (NUM_CH=2, ARG_WIDTH=26, TIMEOUT=16).
module tb_sdcard_cmd_arbiter;

    localparam int unsigned NCH = 2;
    localparam int unsigned AW  = 26;
    localparam int unsigned TO  = 16;

    logic              sd_clk = 1'b0;
    logic              reset_n;
    logic [15:0]       hOp;
    logic [31:0]       hData;
    logic [15:0]       hReqId;
    logic [7:0]        cmd_a [NCH];
    logic [AW-1:0]     arg_a [NCH];
    logic [NCH*8-1:0]  sys_cmd;
    logic [NCH*AW-1:0] sys_arg;
    logic [NCH-1:0]    sys_req;
    logic [NCH-1:0]    sys_done;
    logic [NCH-1:0]    sys_err;
    logic [31:0]       sys_rdata;
    logic              sys_busy;
    logic [7:0]        fCmd;
    logic [31:0]       fArg1;
    logic [15:0]       fReqId;
    logic [31:0]       fDebug_info;
    logic              sdLed;

    assign sys_cmd = {cmd_a[1], cmd_a[0]};
    assign sys_arg = {arg_a[1], arg_a[0]};

    sdcard_cmd_arbiter #(
        .NUM_CH    (NCH),
        .ARG_WIDTH (AW),
        .TIMEOUT   (TO)
    ) dut (
        .sd_clk      (sd_clk),
        .reset_n     (reset_n),
        .hOp         (hOp),
        .hData       (hData),
        .hReqId      (hReqId),
        .sys_cmd     (sys_cmd),
        .sys_arg     (sys_arg),
        .sys_req     (sys_req),
        .sys_done    (sys_done),
        .sys_err     (sys_err),
        .sys_rdata   (sys_rdata),
        .sys_busy    (sys_busy),
        .fCmd        (fCmd),
        .fArg1       (fArg1),
        .fReqId      (fReqId),
        .fDebug_info (fDebug_info),
        .sdLed       (sdLed)
    );

    always #5 sd_clk = ~sd_clk;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_id;
    logic [31:0] exp_rdata;

    typedef struct {
        logic        ch;
        logic [7:0]  cmd;
        logic [25:0] arg;
        logic [15:0] op;
        logic [31:0] data;
        logic [1:0]  exp_done;
        logic [1:0]  exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic tick;
        @(posedge sd_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Toggle one channel's request and check the 2-cycle request-to-fCmd path.
    task automatic issue(input logic ch, input logic [7:0] cmd, input logic [25:0] arg);
        cmd_a[ch]   = cmd;
        arg_a[ch]   = arg;
        sys_req[ch] = ~sys_req[ch];
        tick;
        chk("capture_fCmd_idle", 32'(fCmd), 32'd0);
        tick;
        exp_id = exp_id + 16'd1;
        chk("grant_fCmd", 32'(fCmd), 32'(cmd));
        chk("grant_fArg1", fArg1, {6'd0, arg});
        chk("grant_fReqId", 32'(fReqId), 32'(exp_id));
        chk("grant_busy", 32'(sys_busy), 32'd1);
    endtask

    task automatic respond(input logic [15:0] op, input logic [31:0] data);
        hOp    = op;
        hData  = data;
        hReqId = hReqId + 16'd1;
        tick;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'h03, 26'h0000100, 16'h0005, 32'h0000CAFE, 2'b01, 2'b00};
        vecs[1] = '{1'b1, 8'h11, 26'h3FFFFFF, 16'h0000, 32'h12345678, 2'b10, 2'b00};
        vecs[2] = '{1'b0, 8'hFF, 26'h0000000, 16'h000F, 32'hDEAD0001, 2'b00, 2'b01};
        vecs[3] = '{1'b1, 8'h42, 26'h2AAAAAA, 16'h00F2, 32'h0000BEEF, 2'b10, 2'b00};
        vecs[4] = '{1'b0, 8'h5A, 26'h1555555, 16'hFFFF, 32'h00000BAD, 2'b00, 2'b01};
        vecs[5] = '{1'b1, 8'h07, 26'h0000001, 16'h0003, 32'h89ABCDEF, 2'b10, 2'b00};

        exp_id    = 16'd0;
        exp_rdata = 32'd0;
        cmd_a[0]  = 8'h0;
        cmd_a[1]  = 8'h0;
        arg_a[0]  = '0;
        arg_a[1]  = '0;
        hOp       = 16'd0;
        hData     = 32'd0;

        // 1: reset with requests and response strobe already high
        reset_n = 1'b0;
        sys_req = 2'b11;
        hReqId  = 16'd3;
        repeat (3) tick;
        chk("in_reset_fReqId", 32'(fReqId), 32'd0);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick;
            chk("reset_quiet", 32'({sys_done, sys_err, sys_busy, fCmd}), 32'd0);
        end
        chk("reset_fReqId", 32'(fReqId), 32'd0);
        chk("reset_fArg1", fArg1, 32'd0);
        chk("reset_rdata", sys_rdata, 32'd0);
        chk("reset_sdLed", 32'(sdLed), 32'd0);
        chk("reset_debug", fDebug_info, 32'd0);

        // 2: table of single-channel commands
        for (int k = 0; k < 6; k++) begin
            issue(vecs[k].ch, vecs[k].cmd, vecs[k].arg);
            respond(vecs[k].op, vecs[k].data);
            chk("vec_done", 32'(sys_done), 32'(vecs[k].exp_done));
            chk("vec_err", 32'(sys_err), 32'(vecs[k].exp_err));
            chk("vec_fCmd_cleared", 32'(fCmd), 32'd0);
            chk("vec_busy_cleared", 32'(sys_busy), 32'd0);
            if (vecs[k].exp_done != 2'b00) exp_rdata = vecs[k].data;
            chk("vec_rdata", sys_rdata, exp_rdata);
            tick;
            chk("vec_pulse_end", 32'({sys_done, sys_err}), 32'd0);
        end

        // 3a: simultaneous requests with rr pointer at 0 -> ch0 then ch1
        cmd_a[0] = 8'h21; arg_a[0] = 26'h10;
        cmd_a[1] = 8'h22; arg_a[1] = 26'h20;
        sys_req  = sys_req ^ 2'b11;
        tick;
        tick;
        exp_id = exp_id + 16'd1;
        chk("rr_a_first_cmd", 32'(fCmd), 32'h21);
        chk("rr_a_first_id", 32'(fReqId), 32'(exp_id));
        respond(16'h5, 32'h1111);
        chk("rr_a_first_done", 32'(sys_done), 32'b01);
        chk("rr_a_gap_fCmd", 32'(fCmd), 32'd0);
        tick;
        exp_id = exp_id + 16'd1;
        chk("rr_a_second_cmd", 32'(fCmd), 32'h22);
        chk("rr_a_second_arg", fArg1, 32'h20);
        chk("rr_a_second_id", 32'(fReqId), 32'(exp_id));
        respond(16'h5, 32'h2222);
        chk("rr_a_second_done", 32'(sys_done), 32'b10);
        chk("rr_a_second_rdata", sys_rdata, 32'h2222);
        tick;

        // 3b: after a ch0 command the pointer is at 1 -> ch1 then ch0
        issue(1'b0, 8'h30, 26'h3);
        respond(16'h5, 32'h3333);
        tick;
        cmd_a[0] = 8'h31;
        cmd_a[1] = 8'h32;
        sys_req  = sys_req ^ 2'b11;
        tick;
        tick;
        exp_id = exp_id + 16'd1;
        chk("rr_b_first_cmd", 32'(fCmd), 32'h32);
        respond(16'h5, 32'h4444);
        chk("rr_b_first_done", 32'(sys_done), 32'b10);
        tick;
        exp_id = exp_id + 16'd1;
        chk("rr_b_second_cmd", 32'(fCmd), 32'h31);
        chk("rr_b_second_id", 32'(fReqId), 32'(exp_id));
        respond(16'h5, 32'h5555);
        chk("rr_b_second_done", 32'(sys_done), 32'b01);
        exp_rdata = 32'h5555;
        tick;

        // 4: timeout 16 cycles after entering WAIT, then a stale response
        issue(1'b1, 8'h44, 26'h44);
        repeat (15) tick;
        chk("to_not_yet_err", 32'(sys_err), 32'd0);
        chk("to_not_yet_busy", 32'(sys_busy), 32'd1);
        tick;
        chk("to_err", 32'(sys_err), 32'b10);
        chk("to_fCmd", 32'(fCmd), 32'd0);
        chk("to_busy", 32'(sys_busy), 32'd0);
        tick;
        respond(16'h5, 32'h6666);
        chk("stale_pulses", 32'({sys_done, sys_err}), 32'd0);
        chk("stale_rdata", sys_rdata, exp_rdata);

        // 5: card-ready in WAIT is not a completion; then an HPS error
        chk("led_before", 32'(sdLed), 32'd0);
        issue(1'b0, 8'h55, 26'h55);
        respond(16'h1, 32'h7777);
        chk("ready_led", 32'(sdLed), 32'd1);
        chk("ready_busy", 32'(sys_busy), 32'd1);
        chk("ready_fCmd", 32'(fCmd), 32'h55);
        chk("ready_no_pulse", 32'({sys_done, sys_err}), 32'd0);
        respond(16'hF, 32'h8888);
        chk("hps_err", 32'(sys_err), 32'b01);
        chk("hps_err_no_done", 32'(sys_done), 32'd0);
        chk("hps_err_fCmd", 32'(fCmd), 32'd0);
        tick;

        // 6: ch1 toggled twice while ch0 is in flight -> overrun, one command
        issue(1'b0, 8'h60, 26'h0);
        cmd_a[1]   = 8'h61;
        arg_a[1]   = 26'h61;
        sys_req[1] = ~sys_req[1];
        tick;
        chk("ovr_first_ok", 32'(sys_err), 32'd0);
        sys_req[1] = ~sys_req[1];
        tick;
        chk("ovr_err", 32'(sys_err), 32'b10);
        tick;
        chk("ovr_err_end", 32'(sys_err), 32'd0);
        respond(16'h5, 32'hABCD);
        chk("ovr_ch0_done", 32'(sys_done), 32'b01);
        tick;
        exp_id = exp_id + 16'd1;
        chk("ovr_ch1_cmd", 32'(fCmd), 32'h61);
        chk("ovr_ch1_id", 32'(fReqId), 32'(exp_id));
        respond(16'h5, 32'h1234);
        chk("ovr_ch1_done", 32'(sys_done), 32'b10);
        repeat (5) tick;
        chk("ovr_single_fCmd", 32'(fCmd), 32'd0);
        chk("ovr_single_id", 32'(fReqId), 32'(exp_id));
        chk("ovr_single_busy", 32'(sys_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
